// File: rtl/sysid_checker_master_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// Avalon word addresses of the ID/timestamp registers and the bus data width.
package sysid_checker_master_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } sysid_state_e;

endpackage

// File: rtl/sysid_checker_master.sv
// Avalon-MM master that reads the system-ID and timestamp words of a sysid
// slave, compares them against expected values and reports the outcome.
module sysid_checker_master
  import sysid_checker_master_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1713458669,
  parameter int                      TIMEOUT_CYCLES     = 255
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    address,
  output logic                    read,
  input  logic                    waitrequest,
  input  logic [SYSID_DATA_W-1:0] readdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    id_ok,
  output logic                    ts_ok,
  output logic                    timeout,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  sysid_state_e            state_q;
  logic                    read_q, addr_q, busy_q, done_q;
  logic                    pass_q, id_ok_q, ts_ok_q, timeout_q;
  logic [SYSID_DATA_W-1:0] id_q, ts_q;
  logic [15:0]             stall_q, stall_d;

  assign stall_d = stall_q + 16'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
      stall_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped, not queued.
          if (start && !done_q) begin
            state_q   <= RD_ID;
            read_q    <= 1'b1;
            addr_q    <= SYSID_ADDR_ID;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
          end
        end
        RD_ID: begin
          if (waitrequest) begin
            stall_q <= stall_d;
            if (stall_d >= TIMEOUT_LIM) begin
              read_q    <= 1'b0;
              timeout_q <= 1'b1;
              pass_q    <= 1'b0;
              state_q   <= FINISH;
            end
          end else begin
            id_q    <= readdata;
            id_ok_q <= (readdata == EXPECTED_ID);
            addr_q  <= SYSID_ADDR_TS;
            stall_q <= '0;
            state_q <= RD_TS;
          end
        end
        RD_TS: begin
          if (waitrequest) begin
            stall_q <= stall_d;
            if (stall_d >= TIMEOUT_LIM) begin
              read_q    <= 1'b0;
              timeout_q <= 1'b1;
              pass_q    <= 1'b0;
              state_q   <= FINISH;
            end
          end else begin
            ts_q    <= readdata;
            ts_ok_q <= (readdata == EXPECTED_TIMESTAMP);
            read_q  <= 1'b0;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          pass_q  <= id_ok_q & ts_ok_q & ~timeout_q;
          busy_q  <= 1'b0;
          read_q  <= 1'b0;
          addr_q  <= SYSID_ADDR_ID;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign address  = addr_q;
  assign read     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_q;
  assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_checker_master.sv
// Directed bench for sysid_checker_master with a behavioural sysid slave
// whose ID/timestamp words and waitrequest are set per scenario.
module tb_sysid_checker_master;

  localparam logic [31:0] EXP_TS = 32'd1713458669;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic        address, read, busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] readdata, id_value, ts_value;
  logic [31:0] slv_id = 32'd0;
  logic [31:0] slv_ts = EXP_TS;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign readdata = address ? slv_ts : slv_id;

  sysid_checker_master #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .address    (address),
    .read       (read),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .id_ok      (id_ok),
    .ts_ok      (ts_ok),
    .timeout    (timeout),
    .id_value   (id_value),
    .ts_value   (ts_value)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({read, address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00) begin
      errs++; $display("FAIL reset_ctrl: got %b want 00000000",
                       {read, address, busy, done, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if ({id_value, ts_value} !== 64'd0) begin
      errs++; $display("FAIL reset_values: got %h/%h want 0/0", id_value, ts_value);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    slv_id = 32'd0; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({read, address, busy, done} !== 4'b1010) begin
      errs++; $display("FAIL nom_rd_id: got %b want 1010", {read, address, busy, done});
    end
    tick();
    checks++;
    if ({read, address, busy, done} !== 4'b1110) begin
      errs++; $display("FAIL nom_rd_ts: got %b want 1110", {read, address, busy, done});
    end
    tick();
    checks++;
    if ({read, busy, done} !== 3'b010) begin
      errs++; $display("FAIL nom_finish: got %b want 010", {read, busy, done});
    end
    tick();
    checks++;
    if ({done, busy, read, pass, id_ok, ts_ok, timeout} !== 7'b1001110) begin
      errs++; $display("FAIL nom_done: got %b want 1001110",
                       {done, busy, read, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if (ts_value !== 32'h6621_4DED || id_value !== 32'd0) begin
      errs++; $display("FAIL nom_values: got %h/%h want 00000000/66214ded", id_value, ts_value);
    end
    tick();
    checks++;
    if ({done, pass, address} !== 3'b010) begin
      errs++; $display("FAIL nom_hold: got %b want 010", {done, pass, address});
    end
  endtask

  task automatic test_ts_mismatch();
    slv_id = 32'd0; slv_ts = 32'd1713458670; waitrequest = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({done, pass, id_ok, ts_ok, timeout} !== 5'b10100) begin
      errs++; $display("FAIL ts_mis_flags: got %b want 10100", {done, pass, id_ok, ts_ok, timeout});
    end
    checks++;
    if (ts_value !== 32'd1713458670) begin
      errs++; $display("FAIL ts_mis_value: got %0d want 1713458670", ts_value);
    end
    tick();
  endtask

  task automatic test_id_mismatch();
    slv_id = 32'h0000_0005; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({done, pass, id_ok, ts_ok, timeout, id_value} !== {5'b10010, 32'h5}) begin
      errs++; $display("FAIL id_mis: got %b/%h want 10010/00000005",
                       {done, pass, id_ok, ts_ok, timeout}, id_value);
    end
    tick();
  endtask

  task automatic test_stall();
    int cyc;
    slv_id = 32'd0; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 1;
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++;
      checks++;
      if ({read, address, busy} !== 3'b101) begin
        errs++; $display("FAIL stall_id_%0d: got %b want 101", i, {read, address, busy});
      end
    end
    waitrequest = 1'b0; tick(); cyc++;
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); cyc++;
      checks++;
      if ({read, address, busy} !== 3'b111) begin
        errs++; $display("FAIL stall_ts_%0d: got %b want 111", i, {read, address, busy});
      end
    end
    waitrequest = 1'b0;
    while (!done && cyc < 20) begin
      tick(); cyc++;
    end
    checks++;
    if (cyc !== 10) begin
      errs++; $display("FAIL stall_latency: got %0d cycles want 10", cyc);
    end
    checks++;
    if ({done, pass, timeout} !== 3'b110) begin
      errs++; $display("FAIL stall_pass: got %b want 110", {done, pass, timeout});
    end
    tick();
  endtask

  task automatic test_timeout();
    slv_id = 32'h1234_5678; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (read !== 1'b1) begin
        errs++; $display("FAIL tmo_read_hi_%0d: got %b want 1", i, read);
      end
    end
    tick();
    checks++;
    if ({read, timeout, pass, done} !== 4'b0100) begin
      errs++; $display("FAIL tmo_abort: got %b want 0100", {read, timeout, pass, done});
    end
    tick();
    checks++;
    if ({done, pass, timeout, busy, id_value} !== {4'b1010, 32'd0}) begin
      errs++; $display("FAIL tmo_done: got %b/%h want 1010/00000000",
                       {done, pass, timeout, busy}, id_value);
    end
    waitrequest = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    slv_id = 32'd0; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if ({done, busy} !== 2'b10) begin
      errs++; $display("FAIL b2b_done: got %b want 10", {done, busy});
    end
    tick();
    checks++;
    if ({done, busy, read} !== 3'b000) begin
      errs++; $display("FAIL b2b_start_on_done: got %b want 000", {done, busy, read});
    end
    tick();
    checks++;
    if ({busy, read, address, pass} !== 4'b1100) begin
      errs++; $display("FAIL b2b_restart: got %b want 1100", {busy, read, address, pass});
    end
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({done, pass} !== 2'b11) begin
      errs++; $display("FAIL b2b_second: got %b want 11", {done, pass});
    end
    tick();
  endtask

  task automatic test_busy_reset();
    slv_id = 32'hA5A5_0001; slv_ts = EXP_TS; waitrequest = 1'b0;
    start = 1'b1; tick();
    tick(); start = 1'b0;
    checks++;
    if ({read, address, busy, id_value} !== {3'b111, 32'hA5A5_0001}) begin
      errs++; $display("FAIL busy_start_ignored: got %b/%h want 111/a5a50001",
                       {read, address, busy}, id_value);
    end
    waitrequest = 1'b1; tick();
    reset_n = 1'b0; tick();
    checks++;
    if ({read, address, busy, done, pass, id_ok, ts_ok, timeout} !== 8'h00 ||
        {id_value, ts_value} !== 64'd0) begin
      errs++; $display("FAIL midseq_reset: got %b/%h/%h want 00000000/0/0",
                       {read, address, busy, done, pass, id_ok, ts_ok, timeout},
                       id_value, ts_value);
    end
    reset_n = 1'b1; waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({done, busy, read} !== 3'b000) begin
        errs++; $display("FAIL post_reset_%0d: got %b want 000", i, {done, busy, read});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ts_mismatch();
    test_id_mismatch();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_busy_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
